// File: rtl/trace_mem_cmd_sequencer.sv
// trace_mem_cmd_sequencer: issues one trace-replay command at a time to the tile's wr/rd ports and gates its data beats
module trace_mem_cmd_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int SIZE_W    = 16,
  parameter int DATA_W    = 256,
  parameter int PAD_W     = 5,
  parameter int TIMEOUT_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_val,
  output logic              cmd_rdy,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [SIZE_W-1:0] cmd_size,
  output logic              wr_req_val,
  input  logic              wr_req_rdy,
  output logic [ADDR_W-1:0] wr_req_addr,
  output logic [SIZE_W-1:0] wr_req_size,
  output logic              rd_req_val,
  input  logic              rd_req_rdy,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [SIZE_W-1:0] rd_req_size,
  input  logic              src_val,
  output logic              src_rdy,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_last,
  input  logic [PAD_W-1:0]  src_padbytes,
  output logic              wr_data_val,
  input  logic              wr_data_rdy,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_data_last,
  output logic [PAD_W-1:0]  wr_data_padbytes,
  input  logic              rd_data_val,
  output logic              rd_data_rdy,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_last,
  input  logic [PAD_W-1:0]  rd_data_padbytes,
  output logic              snk_val,
  input  logic              snk_rdy,
  output logic [DATA_W-1:0] snk_data,
  output logic              snk_last,
  output logic [PAD_W-1:0]  snk_padbytes,
  output logic              busy,
  output logic              err_len,
  output logic              err_timeout,
  output logic [15:0]       done_cnt
);
  localparam int BYTES = DATA_W / 8;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [SIZE_W-1:0] size_q, exp_beats, beat_cnt;
  logic [PAD_W-1:0] exp_pad, b_pad;
  logic [TIMEOUT_W-1:0] to_cnt;
  logic [SIZE_W:0] beats_w, pad_w;
  logic in_wr, in_rd, wr_beat, rd_beat, beat, b_last;
  assign beats_w = ({1'b0, cmd_size} + (SIZE_W+1)'(BYTES-1)) / (SIZE_W+1)'(BYTES);
  assign pad_w   = beats_w * (SIZE_W+1)'(BYTES) - {1'b0, cmd_size};
  assign in_wr = state == WR_DATA;
  assign in_rd = state == RD_DATA;
  // cmd_rdy is qualified by rst_n so every ready output is low while reset is held
  assign cmd_rdy          = rst_n && state == IDLE;
  assign busy             = state != IDLE;
  assign wr_req_val       = state == WR_REQ;
  assign wr_req_addr      = wr_req_val ? addr_q : '0;
  assign wr_req_size      = wr_req_val ? size_q : '0;
  assign rd_req_val       = state == RD_REQ;
  assign rd_req_addr      = rd_req_val ? addr_q : '0;
  assign rd_req_size      = rd_req_val ? size_q : '0;
  assign src_rdy          = in_wr & wr_data_rdy;
  assign wr_data_val      = in_wr & src_val;
  assign wr_data          = in_wr ? src_data : '0;
  assign wr_data_last     = in_wr & src_last;
  assign wr_data_padbytes = in_wr ? src_padbytes : '0;
  assign rd_data_rdy      = in_rd & snk_rdy;
  assign snk_val          = in_rd & rd_data_val;
  assign snk_data         = in_rd ? rd_data : '0;
  assign snk_last         = in_rd & rd_data_last;
  assign snk_padbytes     = in_rd ? rd_data_padbytes : '0;
  assign wr_beat = src_val & src_rdy;
  assign rd_beat = rd_data_val & rd_data_rdy;
  assign beat    = wr_beat | rd_beat;
  assign b_last  = in_wr ? src_last : rd_data_last;
  assign b_pad   = in_wr ? src_padbytes : rd_data_padbytes;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:             if (cmd_val && cmd_size != '0) state_nx = cmd_op ? RD_REQ : WR_REQ;
      WR_REQ:           if (wr_req_rdy) state_nx = WR_DATA;
      RD_REQ:           if (rd_req_rdy) state_nx = RD_DATA;
      WR_DATA, RD_DATA: if (beat && b_last) state_nx = IDLE;
      default:          state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      size_q      <= '0;
      exp_beats   <= '0;
      exp_pad     <= '0;
      beat_cnt    <= '0;
      to_cnt      <= '0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      done_cnt    <= '0;
    end else begin
      if (state == IDLE && cmd_val) begin
        addr_q    <= cmd_addr;
        size_q    <= cmd_size;
        exp_beats <= beats_w[SIZE_W-1:0];
        exp_pad   <= pad_w[PAD_W-1:0];
        beat_cnt  <= '0;
        if (cmd_size == '0) err_len <= 1'b1;
      end
      if (beat) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (b_last) begin
          done_cnt <= done_cnt + 1'b1;
          if (beat_cnt + 1'b1 != exp_beats || b_pad != exp_pad) err_len <= 1'b1;
        end else if (beat_cnt + 1'b1 >= exp_beats) err_len <= 1'b1;
      end
      // counter reaches all-ones on the same edge err_timeout rises, then holds
      if (state == RD_REQ) to_cnt <= '0;
      else if (in_rd) to_cnt <= rd_beat ? '0 : (&to_cnt ? to_cnt : to_cnt + 1'b1);
      if (in_rd && !rd_beat && to_cnt == {{(TIMEOUT_W-1){1'b1}}, 1'b0}) err_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_trace_mem_cmd_sequencer.sv
// tb_trace_mem_cmd_sequencer: randomized directed bench against a size/beat/pad reference model
module tb_trace_mem_cmd_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic cmd_val, cmd_rdy, cmd_op;
  logic [31:0] cmd_addr, wr_req_addr, rd_req_addr;
  logic [15:0] cmd_size, wr_req_size, rd_req_size, done_cnt;
  logic wr_req_val, wr_req_rdy, rd_req_val, rd_req_rdy;
  logic src_val, src_rdy, src_last, wr_data_val, wr_data_rdy, wr_data_last;
  logic rd_data_val, rd_data_rdy, rd_data_last, snk_val, snk_rdy, snk_last;
  logic [255:0] src_data, wr_data, rd_data, snk_data;
  logic [4:0] src_padbytes, wr_data_padbytes, rd_data_padbytes, snk_padbytes;
  logic busy, err_len, err_timeout;
  int total = 0, bad = 0;
  int m_done = 0;
  bit m_len = 0, m_to = 0;
  trace_mem_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
    .wr_req_val(wr_req_val), .wr_req_rdy(wr_req_rdy), .wr_req_addr(wr_req_addr), .wr_req_size(wr_req_size),
    .rd_req_val(rd_req_val), .rd_req_rdy(rd_req_rdy), .rd_req_addr(rd_req_addr), .rd_req_size(rd_req_size),
    .src_val(src_val), .src_rdy(src_rdy), .src_data(src_data), .src_last(src_last), .src_padbytes(src_padbytes),
    .wr_data_val(wr_data_val), .wr_data_rdy(wr_data_rdy), .wr_data(wr_data), .wr_data_last(wr_data_last),
    .wr_data_padbytes(wr_data_padbytes),
    .rd_data_val(rd_data_val), .rd_data_rdy(rd_data_rdy), .rd_data(rd_data), .rd_data_last(rd_data_last),
    .rd_data_padbytes(rd_data_padbytes),
    .snk_val(snk_val), .snk_rdy(snk_rdy), .snk_data(snk_data), .snk_last(snk_last), .snk_padbytes(snk_padbytes),
    .busy(busy), .err_len(err_len), .err_timeout(err_timeout), .done_cnt(done_cnt)
  );
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) cyc();
    m_done = 0; m_len = 0; m_to = 0;
    rst_n = 1'b1;
    cyc();
  endtask
  task automatic run_cmd(input bit op, input logic [31:0] a, input logic [15:0] sz, input int nb,
                         input logic [4:0] pad, input int req_dly, input int stall, input bit rnd);
    int eb, ep;
    logic [255:0] d;
    bit lst, r;
    cmd_val = 1'b1; cmd_op = op; cmd_addr = a; cmd_size = sz;
    #1;
    chk("cmd_rdy", cmd_rdy, 1);
    cyc();
    cmd_val = 1'b0; cmd_addr = '0; cmd_size = '0;
    if (sz == 0) begin
      m_len = 1;
      chk("z_busy", busy, 0);
      chk("z_wrq", wr_req_val, 0);
      chk("z_rdq", rd_req_val, 0);
      chk("z_len", err_len, m_len);
      chk("z_done", done_cnt, m_done);
      return;
    end
    eb = (sz + 31) / 32;
    ep = eb * 32 - sz;
    for (int k = 0; k <= req_dly; k++) begin
      if (op) rd_req_rdy = (k == req_dly); else wr_req_rdy = (k == req_dly);
      #1;
      chk("req_val", op ? rd_req_val : wr_req_val, 1);
      chk("req_other", op ? wr_req_val : rd_req_val, 0);
      chk("req_addr", op ? rd_req_addr : wr_req_addr, a);
      chk("req_size", op ? rd_req_size : wr_req_size, sz);
      cyc();
    end
    wr_req_rdy = 1'b0; rd_req_rdy = 1'b0;
    if (stall > 0) begin
      repeat (stall - 1) cyc();
      chk("to_pre", err_timeout, m_to);
      cyc();
      if (stall >= 4095) m_to = 1;
      chk("to_post", err_timeout, m_to);
    end
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
      lst = (i == nb - 1);
      if (rnd && $urandom_range(0, 3) == 0) begin
        src_val = 1'b0; rd_data_val = 1'b0;
        #1;
        chk("gap_val", op ? snk_val : wr_data_val, 0);
        cyc();
      end
      if (op) begin
        rd_data_val = 1'b1; rd_data = d; rd_data_last = lst;
        rd_data_padbytes = lst ? pad : 5'($urandom);
        src_val = rnd; src_last = 1'b1; wr_data_rdy = 1'b1;
      end else begin
        src_val = 1'b1; src_data = d; src_last = lst;
        src_padbytes = lst ? pad : 5'($urandom);
        rd_data_val = rnd; rd_data_last = 1'b1; snk_rdy = 1'b1;
      end
      for (int k = 0; k < 40; k++) begin
        r = !rnd || k >= 20 || $urandom_range(0, 1) == 1;
        if (op) snk_rdy = r; else wr_data_rdy = r;
        #1;
        chk("cmd_rdy_busy", cmd_rdy, 0);
        if (op) begin
          chk("snk_val", snk_val, 1);
          chk("snk_data", snk_data, d);
          chk("snk_last", snk_last, lst);
          if (lst) chk("snk_pad", snk_padbytes, pad);
          chk("rd_rdy", rd_data_rdy, r);
          chk("stray_src_rdy", src_rdy, 0);
          chk("stray_wr_val", wr_data_val, 0);
        end else begin
          chk("wr_val", wr_data_val, 1);
          chk("wr_data", wr_data, d);
          chk("wr_last", wr_data_last, lst);
          if (lst) chk("wr_pad", wr_data_padbytes, pad);
          chk("src_rdy", src_rdy, r);
          chk("stray_rd_rdy", rd_data_rdy, 0);
          chk("stray_snk_val", snk_val, 0);
        end
        cyc();
        if (r) break;
      end
    end
    src_val = 1'b0; rd_data_val = 1'b0; wr_data_rdy = 1'b0; snk_rdy = 1'b0;
    m_done++;
    if (nb != eb || pad != ep) m_len = 1;
    chk("end_busy", busy, 0);
    chk("end_cmd_rdy", cmd_rdy, 1);
    chk("done_cnt", done_cnt, m_done);
    chk("err_len", err_len, m_len);
    chk("err_timeout", err_timeout, m_to);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
  initial begin
    int sz, nb;
    cmd_val = 0; cmd_op = 0; cmd_addr = '0; cmd_size = '0;
    wr_req_rdy = 0; rd_req_rdy = 0;
    src_val = 0; src_data = '0; src_last = 0; src_padbytes = '0; wr_data_rdy = 0;
    rd_data_val = 0; rd_data = '0; rd_data_last = 0; rd_data_padbytes = '0; snk_rdy = 0;
    #1;
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrq", wr_req_val, 0);
    chk("rst_wrq_addr", wr_req_addr, 0);
    chk("rst_done", done_cnt, 0);
    chk("rst_errs", {err_len, err_timeout}, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    src_val = 1; rd_data_val = 1; wr_data_rdy = 1; snk_rdy = 1;
    #1;
    chk("idle_src_rdy", src_rdy, 0);
    chk("idle_wr_val", wr_data_val, 0);
    chk("idle_rd_rdy", rd_data_rdy, 0);
    chk("idle_snk_val", snk_val, 0);
    chk("idle_cmd_rdy", cmd_rdy, 1);
    src_val = 0; rd_data_val = 0; wr_data_rdy = 0; snk_rdy = 0;
    cyc();
    run_cmd(0, 32'h100, 16'd64, 2, 5'd0, 0, 0, 0);
    run_cmd(1, 32'h180, 16'd40, 2, 5'd24, 1, 0, 0);
    run_cmd(1, 32'h1c0, 16'd40, 2, 5'd0, 0, 0, 0);
    run_cmd(1, 32'h300, 16'd40, 2, 5'd24, 20, 4095, 0);
    src_val = 1; src_data = 256'h5a; src_last = 0;
    cmd_val = 1; cmd_op = 0; cmd_addr = 32'h200; cmd_size = 16'd64;
    cyc();
    cmd_val = 0; wr_req_rdy = 1;
    cyc();
    wr_req_rdy = 0; wr_data_rdy = 1;
    cyc();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_wr_val", wr_data_val, 0);
    chk("arst_src_rdy", src_rdy, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cmd_rdy", cmd_rdy, 0);
    chk("arst_errs", {err_len, err_timeout}, 0);
    chk("arst_done", done_cnt, 0);
    m_done = 0; m_len = 0; m_to = 0;
    src_val = 0; wr_data_rdy = 0;
    cyc();
    rst_n = 1'b1;
    cyc();
    run_cmd(0, 32'h400, 16'd32, 1, 5'd0, 0, 0, 0);
    for (int n = 0; n < 12; n++) begin
      sz = $urandom_range(1, 200);
      nb = (sz + 31) / 32;
      run_cmd(1'($urandom), $urandom, 16'(sz), nb, 5'(nb * 32 - sz), $urandom_range(0, 3), 0, 1);
    end
    do_reset();
    run_cmd(0, 32'h500, 16'd0, 0, 5'd0, 0, 0, 0);
    do_reset();
    run_cmd(0, 32'h600, 16'd96, 2, 5'd0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
